// File: rtl/fir_mc_serial.sv
// Multi-channel order-N FIR filter built around one shared multiplier that
// handles one tap per cycle. Each channel has its own delay line; all channels
// share one coefficient bank. Results are saturated.
`timescale 1ns/1ps
module fir_mc_serial #(
    parameter int WIX = 4,
    parameter int WFX = 5,
    parameter int WIC = 4,
    parameter int WFC = 5,
    parameter int WIY = WIX + WIC,
    parameter int N   = 4,
    parameter int NCH = 2,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW = (N > 0) ? $clog2(N + 1) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_x_valid,
    output logic                          o_x_ready,
    input  logic [CW-1:0]                 i_x_ch,
    input  logic signed [WIX+WFX-1:0]     i_x,
    input  logic                          i_coef_we,
    input  logic [AW-1:0]                 i_coef_addr,
    input  logic signed [WIC+WFC-1:0]     i_coef_data,
    output logic                          o_y_valid,
    output logic [CW-1:0]                 o_y_ch,
    output logic signed [WIY+WFX+WFC-1:0] o_y,
    output logic                          o_y_sat,
    output logic                          o_of_sat,
    input  logic                          i_of_clr
);
    localparam int WX   = WIX + WFX;
    localparam int WC   = WIC + WFC;
    localparam int WY   = WIY + WFX + WFC;
    localparam int PW   = WIX + WIC + WFX + WFC;
    localparam int ACCW = PW + AW;
    localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-WY+1){1'b0}}, {(WY-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-WY+1){1'b1}}, {(WY-1){1'b0}}};

    typedef enum logic {S_IDLE, S_MAC} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_rdy_en;
    logic [AW-1:0]           r_k;
    logic [CW-1:0]           r_ch;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [WX-1:0]    r_hist [NCH][N+1];
    logic signed [WC-1:0]    r_coef [N+1];
    logic                    r_y_valid, r_y_sat, r_of;
    logic [CW-1:0]           r_y_ch;
    logic signed [WY-1:0]    r_y;

    logic                    w_xfer, w_ch_ok, w_last, w_hi, w_lo;
    logic signed [PW-1:0]    w_hx, w_cx, w_prod;
    logic signed [ACCW-1:0]  w_sum;

    // Ready stays low for the first edge after reset release.
    assign o_x_ready = r_rdy_en && (r_state == S_IDLE);
    assign w_xfer    = i_x_valid && o_x_ready;
    assign w_ch_ok   = ({1'b0, i_x_ch} < (CW+1)'(NCH));
    assign w_last    = (r_state == S_MAC) && (r_k == AW'(N));

    assign w_hx   = PW'(r_hist[r_ch][r_k]);
    assign w_cx   = PW'(r_coef[r_k]);
    assign w_prod = w_hx * w_cx;
    assign w_sum  = r_acc + ACCW'(w_prod);
    assign w_hi   = (w_sum > YMAX);
    assign w_lo   = (w_sum < YMIN);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer && w_ch_ok) w_state_nxt = S_MAC;
            S_MAC:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rdy_en  <= 1'b0;
            r_k       <= '0;
            r_ch      <= '0;
            r_acc     <= '0;
            r_y_valid <= 1'b0;
            r_y_sat   <= 1'b0;
            r_y_ch    <= '0;
            r_y       <= '0;
            r_of      <= 1'b0;
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t <= N; t++) r_hist[c][t] <= '0;
            for (int t = 0; t <= N; t++) r_coef[t] <= '0;
        end else begin
            r_rdy_en  <= 1'b1;
            r_y_valid <= 1'b0;
            r_of      <= (r_y_valid && r_y_sat) || (r_of && !i_of_clr);
            if (r_state == S_IDLE) begin
                // Coefficient reads start one edge after a transfer, so a
                // write on the transfer edge is seen by that computation.
                if (i_coef_we && (i_coef_addr <= AW'(N)))
                    r_coef[i_coef_addr] <= i_coef_data;
                if (w_xfer && w_ch_ok) begin
                    for (int t = N; t > 0; t--) r_hist[i_x_ch][t] <= r_hist[i_x_ch][t-1];
                    r_hist[i_x_ch][0] <= i_x;
                    r_ch  <= i_x_ch;
                    r_k   <= '0;
                    r_acc <= '0;
                end
            end else begin
                r_acc <= w_sum;
                r_k   <= w_last ? '0 : r_k + AW'(1);
                if (w_last) begin
                    r_y_valid <= 1'b1;
                    r_y_ch    <= r_ch;
                    r_y_sat   <= w_hi || w_lo;
                    r_y       <= w_hi ? YMAX[WY-1:0] : (w_lo ? YMIN[WY-1:0] : w_sum[WY-1:0]);
                end
            end
        end
    end

    assign o_y_valid = r_y_valid;
    assign o_y_ch    = r_y_ch;
    assign o_y       = r_y;
    assign o_y_sat   = r_y_sat;
    assign o_of_sat  = r_of;
endmodule

// File: tb/tb_fir_mc_serial.sv
// Directed and randomized checks of fir_mc_serial against a per-channel
// sum-of-products reference with clamping.
`timescale 1ns/1ps
module tb_fir_mc_serial;
    localparam int N = 4, NCH = 2, CW = 1, AW = 3, WX = 9, WC = 9, WY = 18;
    localparam longint YMAX = (64'sd1 <<< (WY-1)) - 1;
    localparam longint YMIN = -(64'sd1 <<< (WY-1));

    logic                 clk = 1'b0, rst_n = 1'b0;
    logic                 i_x_valid = 1'b0, i_coef_we = 1'b0, i_of_clr = 1'b0;
    logic [CW-1:0]        i_x_ch = '0;
    logic signed [WX-1:0] i_x = '0;
    logic [AW-1:0]        i_coef_addr = '0;
    logic signed [WC-1:0] i_coef_data = '0;
    logic                 o_x_ready, o_y_valid, o_y_sat, o_of_sat;
    logic [CW-1:0]        o_y_ch;
    logic signed [WY-1:0] o_y;

    always #5 clk = ~clk;

    fir_mc_serial dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_x_valid(i_x_valid), .o_x_ready(o_x_ready),
        .i_x_ch(i_x_ch), .i_x(i_x), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
        .i_coef_data(i_coef_data), .o_y_valid(o_y_valid), .o_y_ch(o_y_ch), .o_y(o_y),
        .o_y_sat(o_y_sat), .o_of_sat(o_of_sat), .i_of_clr(i_of_clr)
    );

    int checks = 0, errors = 0;
    int mcoef [N+1];
    int mhist [NCH][N+1];
    int qy[$], qc[$], qs[$];
    logic signed [WY-1:0] last_y;
    int c1  [5] = '{16, 8, -4, 32, 0};
    int imp [5] = '{512, 256, -128, 1024, 0};
    int satv[3] = '{65025, 130050, 131071};

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: newest sample at hist[0]; y = sum hist[k]*coef[k], clamped.
    function automatic void model(input int ch, input int x, output int y, output int s);
        longint acc = 0;
        for (int k = N; k > 0; k--) mhist[ch][k] = mhist[ch][k-1];
        mhist[ch][0] = x;
        for (int k = 0; k <= N; k++) acc += longint'(mhist[ch][k]) * longint'(mcoef[k]);
        s = (acc > YMAX || acc < YMIN) ? 1 : 0;
        y = int'((acc > YMAX) ? YMAX : ((acc < YMIN) ? YMIN : acc));
    endfunction

    task automatic m_clear();
        for (int k = 0; k <= N; k++) begin
            mcoef[k] = 0;
            for (int c = 0; c < NCH; c++) mhist[c][k] = 0;
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_rdy"}, o_x_ready, 0);
        chk({tag, "_vld"}, o_y_valid, 0);
        chk({tag, "_y"}, o_y, 0);
        chk({tag, "_ych"}, o_y_ch, 0);
        chk({tag, "_ysat"}, o_y_sat, 0);
        chk({tag, "_of"}, o_of_sat, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; i_x_valid = 1'b0; i_coef_we = 1'b0; i_of_clr = 1'b0;
        #1 chk_zero_outs("rst");
        m_clear();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rdy_hold", o_x_ready, 0);
        @(negedge clk);
        chk("rdy_after_rst", o_x_ready, 1);
    endtask

    task automatic wr_coef(input int a, input int d);
        i_coef_we = 1'b1; i_coef_addr = AW'(a); i_coef_data = WC'(d);
        if (a <= N) mcoef[a] = d;
        @(negedge clk);
        i_coef_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_x_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", o_x_ready, 1);
    endtask

    // One transfer (optionally with a coefficient write on the same edge, and
    // optionally a write attempt during MAC), then the result check.
    task automatic do_sample(input int ch, input int x, input bit we, input int wa,
                             input int wd, input bit busy);
        int ey, es;
        wait_ready();
        i_x_valid = 1'b1; i_x_ch = CW'(ch); i_x = WX'(x);
        i_coef_we = we; i_coef_addr = AW'(wa); i_coef_data = WC'(wd);
        if (we && wa <= N) mcoef[wa] = wd;
        model(ch, x, ey, es);
        @(negedge clk);
        i_x_valid = 1'b0; i_coef_we = busy;
        i_coef_addr = AW'($urandom_range(0, N)); i_coef_data = WC'($urandom);
        chk("busy_rdy", o_x_ready, 0);
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            i_coef_we = 1'b0;
            if (i < 6) chk("early_vld", o_y_valid, 0);
        end
        chk("y_vld", o_y_valid, 1);
        chk("rdy_with_vld", o_x_ready, 1);
        chk("y", o_y, ey);
        chk("y_ch", o_y_ch, ch);
        chk("y_sat", o_y_sat, es);
        last_y = o_y;
    endtask

    task automatic load_test1();
        for (int k = 0; k <= N; k++) wr_coef(k, c1[k]);
    endtask

    task automatic run_test1();
        for (int i = 0; i < 5; i++) begin
            do_sample(0, (i == 0) ? 32 : 0, 1'b0, 0, 0, 1'b0);
            chk("t1_impulse", last_y, imp[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ey, es;
        // Reset and impulse response
        do_reset();
        load_test1();
        run_test1();

        // Channel isolation
        for (int i = 0; i < 5; i++) begin
            do_sample(0, (i == 0) ? 32 : 0, 1'b0, 0, 0, 1'b0);
            chk("t2_ch0", last_y, imp[i]);
            do_sample(1, 0, 1'b0, 0, 0, 1'b0);
            chk("t2_ch1", last_y, 0);
        end

        // Saturation and sticky flag
        do_reset();
        for (int k = 0; k <= N; k++) wr_coef(k, 255);
        for (int i = 0; i < 3; i++) begin
            do_sample(0, 255, 1'b0, 0, 0, 1'b0);
            chk("t3_y", last_y, satv[i]);
            chk("t3_sat", o_y_sat, (i == 2));
            if (i < 2) chk("t3_of_clear", o_of_sat, 0);
        end
        @(negedge clk);
        chk("t3_of_set", o_of_sat, 1);
        do_sample(1, 1, 1'b0, 0, 0, 1'b0);
        chk("t3_of_sticky", o_of_sat, 1);
        i_of_clr = 1'b1; @(negedge clk); i_of_clr = 1'b0;
        chk("t3_of_clr", o_of_sat, 0);
        do_sample(0, 255, 1'b0, 0, 0, 1'b0);
        i_of_clr = 1'b1; @(negedge clk); i_of_clr = 1'b0;
        chk("t3_set_wins", o_of_sat, 1);
        i_of_clr = 1'b1; @(negedge clk); i_of_clr = 1'b0;
        chk("t3_of_clr2", o_of_sat, 0);

        // Handshake with X_VALID held high: ready 1-in-6, result 6 negedges later
        for (int k = 0; k <= N; k++) wr_coef(k, int'($urandom_range(0, 511)) - 256);
        wait_ready();
        i_x_valid = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            chk("t4_rdy", o_x_ready, (j % 6) == 0);
            chk("t4_vld", o_y_valid, (j >= 6) && ((j % 6) == 0));
            if (o_y_valid && qy.size() > 0) begin
                chk("t4_y", o_y, qy.pop_front());
                chk("t4_ych", o_y_ch, qc.pop_front());
                chk("t4_ysat", o_y_sat, qs.pop_front());
            end
            if (j < 24) begin
                i_x_ch = CW'($urandom_range(0, NCH-1));
                i_x = WX'($urandom);
                if (o_x_ready) begin
                    model(int'(i_x_ch), int'(i_x), ey, es);
                    qy.push_back(ey); qc.push_back(int'(i_x_ch)); qs.push_back(es);
                end
                @(negedge clk);
            end else i_x_valid = 1'b0;
        end
        chk("t4_drained", qy.size(), 0);

        // Reset while k=2: no result, outputs zero, state fully cleared
        load_test1();
        wait_ready();
        i_x_valid = 1'b1; i_x_ch = '0; i_x = WX'(32);
        @(negedge clk); i_x_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero_outs("t5_abort");
        m_clear();
        repeat (2) begin @(negedge clk); chk("t5_no_vld", o_y_valid, 0); end
        #2 rst_n = 1'b1;
        repeat (8) begin @(negedge clk); chk("t5_no_vld_after", o_y_valid, 0); end
        load_test1();
        run_test1();

        // Coefficient writes: ignored during MAC, honoured in IDLE and on transfer edge
        do_sample(0, 32, 1'b0, 0, 0, 1'b1);
        chk("t6_busy_ignored", last_y, 512);
        wr_coef(0, 100);
        do_sample(0, 32, 1'b0, 0, 0, 1'b0);
        chk("t6_idle_write", last_y, 3456);
        do_sample(0, 0, 1'b1, 1, -16, 1'b0);
        chk("t6_write_on_xfer", last_y, -640);

        // Randomized traffic with occasional coefficient writes
        for (int i = 0; i < 40; i++)
            do_sample(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 511)) - 256,
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 511)) - 256, ($urandom_range(0, 3) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
